lsu_bus_ctrl: RTL and testbench

LSU_BUS_CTRL -- requirements
Module: lsu_bus_ctrl

---
 rtl/lsu_bus_ctrl.sv | 152 +++++++++++++++
 tb/tb_lsu_bus_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/lsu_bus_ctrl.sv
// rtl/lsu_bus_ctrl.sv - load/store unit to AHB-Lite single-transfer bus controller.
// Optional misalignment trap enabled by defining LSU_MISALIGN_CHECK_EN.
module lsu_bus_ctrl (
   input  logic        s_clk_i,
   input  logic        s_reset_i,
   input  logic        s_req_i,
   input  logic        s_we_i,
   input  logic [31:0] s_addr_i,
   input  logic [31:0] s_wdata_i,
   input  logic [1:0]  s_size_i,
   input  logic        s_unsigned_i,
   input  logic        s_flush_i,
   output logic        s_stall_o,
   output logic [4:0]  s_ld_info_o,
   output logic [31:0] s_ldata_o,
   output logic        s_ldata_val_o,
   output logic        s_done_o,
   output logic        s_err_o,
   output logic [31:0] s_haddr_o,
   output logic        s_hwrite_o,
   output logic [2:0]  s_hsize_o,
   output logic [1:0]  s_htrans_o,
   output logic [31:0] s_hwdata_o,
   input  logic [31:0] s_hrdata_i,
   input  logic        s_hready_i,
   input  logic        s_hresp_i
);

   typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2, MERR = 2'd3} state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   state_t      state_q;
   logic        flush_q;
   logic        done_q, err_q, ldata_val_q;
   logic [4:0]  ld_info_q;
   logic [31:0] ldata_q;
   logic [31:0] haddr_q, hwdata_q;
   logic        hwrite_q;
   logic [2:0]  hsize_q;
   logic [1:0]  htrans_q;

   logic [31:0] haddr_d, hwdata_d;
   logic [4:0]  ld_info_d;
   logic        flush_d;

   always_comb begin
      haddr_d = s_addr_i;
      if (s_size_i == 2'b01) haddr_d[0] = 1'b0;
      if (s_size_i[1])       haddr_d[1:0] = 2'b00;
      case (s_size_i)
         2'b00:   hwdata_d = {4{s_wdata_i[7:0]}};
         2'b01:   hwdata_d = {2{s_wdata_i[15:0]}};
         default: hwdata_d = s_wdata_i;
      endcase
      ld_info_d = {s_unsigned_i, s_size_i == 2'b10, s_size_i == 2'b01, s_addr_i[1:0]};
   end

   // A flush seen in any cycle of the transfer, including the completing one, kills the pulses.
   assign flush_d = flush_q | s_flush_i;

`ifdef LSU_MISALIGN_CHECK_EN
   logic misalign_d;
   assign misalign_d = ((s_size_i == 2'b01) && s_addr_i[0]) ||
                       (s_size_i[1] && (s_addr_i[1:0] != 2'b00));
`endif

   always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
         state_q     <= IDLE;
         flush_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ldata_val_q <= 1'b0;
         ld_info_q   <= 5'd0;
         ldata_q     <= 32'd0;
         haddr_q     <= 32'd0;
         hwdata_q    <= 32'd0;
         hwrite_q    <= 1'b0;
         hsize_q     <= 3'd0;
         htrans_q    <= HTRANS_IDLE;
      end else begin
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         ldata_val_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (s_req_i) begin
                  ld_info_q <= ld_info_d;
                  flush_q   <= s_flush_i;
`ifdef LSU_MISALIGN_CHECK_EN
                  if (misalign_d) begin
                     state_q <= MERR;
                     done_q  <= ~s_flush_i;
                     err_q   <= ~s_flush_i;
                  end else
`endif
                  begin
                     state_q  <= ADDR;
                     htrans_q <= HTRANS_NONSEQ;
                     haddr_q  <= haddr_d;
                     hsize_q  <= {1'b0, s_size_i};
                     hwrite_q <= s_we_i;
                     hwdata_q <= hwdata_d;
                  end
               end
            end
            ADDR: begin
               flush_q <= flush_d;
               if (s_hready_i) begin
                  state_q  <= DATA;
                  htrans_q <= HTRANS_IDLE;
               end
            end
            DATA: begin
               flush_q <= flush_d;
               // hresp with hready low is the first half of an error response: just wait.
               if (s_hready_i) begin
                  state_q <= IDLE;
                  done_q  <= ~flush_d;
                  if (s_hresp_i) begin
                     err_q <= ~flush_d;
                  end else if (!hwrite_q && !flush_d) begin
                     ldata_q     <= s_hrdata_i;
                     ldata_val_q <= 1'b1;
                  end
               end
            end
            MERR: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign s_stall_o     = (state_q != IDLE);
   assign s_ld_info_o   = ld_info_q;
   assign s_ldata_o     = ldata_q;
   assign s_ldata_val_o = ldata_val_q;
   assign s_done_o      = done_q;
   assign s_err_o       = err_q;
   assign s_haddr_o     = haddr_q;
   assign s_hwrite_o    = hwrite_q;
   assign s_hsize_o     = hsize_q;
   assign s_htrans_o    = htrans_q;
   assign s_hwdata_o    = hwdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// tb/tb_lsu_bus_ctrl.sv - randomized self-checking bench for lsu_bus_ctrl against a transaction-level model.
module tb_lsu_bus_ctrl;

   logic        s_clk_i = 1'b0;
   logic        s_reset_i = 1'b1;
   logic        s_req_i = 1'b0, s_we_i = 1'b0, s_unsigned_i = 1'b0, s_flush_i = 1'b0;
   logic [31:0] s_addr_i = 32'd0, s_wdata_i = 32'd0, s_hrdata_i = 32'd0;
   logic [1:0]  s_size_i = 2'd0;
   logic        s_hready_i = 1'b0, s_hresp_i = 1'b0;
   logic        s_stall_o, s_ldata_val_o, s_done_o, s_err_o, s_hwrite_o;
   logic [4:0]  s_ld_info_o;
   logic [31:0] s_ldata_o, s_haddr_o, s_hwdata_o;
   logic [2:0]  s_hsize_o;
   logic [1:0]  s_htrans_o;

   int n_checks = 0;
   int n_fail = 0;
   logic [31:0] last_ldata = 32'd0;
   logic        ldata_known = 1'b1;

   always #5 s_clk_i = ~s_clk_i;

   lsu_bus_ctrl dut (
      .s_clk_i(s_clk_i), .s_reset_i(s_reset_i), .s_req_i(s_req_i), .s_we_i(s_we_i),
      .s_addr_i(s_addr_i), .s_wdata_i(s_wdata_i), .s_size_i(s_size_i),
      .s_unsigned_i(s_unsigned_i), .s_flush_i(s_flush_i), .s_stall_o(s_stall_o),
      .s_ld_info_o(s_ld_info_o), .s_ldata_o(s_ldata_o), .s_ldata_val_o(s_ldata_val_o),
      .s_done_o(s_done_o), .s_err_o(s_err_o), .s_haddr_o(s_haddr_o), .s_hwrite_o(s_hwrite_o),
      .s_hsize_o(s_hsize_o), .s_htrans_o(s_htrans_o), .s_hwdata_o(s_hwdata_o),
      .s_hrdata_i(s_hrdata_i), .s_hready_i(s_hready_i), .s_hresp_i(s_hresp_i)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // One core request served by a slave that inserts aw address-phase and dw data-phase
   // wait states; fc is the cycle (0 = acceptance) in which flush is raised, -1 for none.
   task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] size, input logic uns, input int aw, input int dw,
                          input logic errr, input int fc, input logic [31:0] rdata);
      int          last, guard;
      logic        fl, mis, ev;
      logic [31:0] ea, ew;
      logic [4:0]  ei;
      guard = 0;
      while (s_stall_o && guard < 50) begin
         @(negedge s_clk_i);
         guard++;
      end
      if (guard >= 50) check("idle_timeout", 32'd1, 32'd0);
      ei = {uns, size == 2'd2, size == 2'd1, addr[1:0]};
      if (size == 2'd2)      ea = addr & ~32'd3;
      else if (size == 2'd1) ea = addr & ~32'd1;
      else                   ea = addr;
      if (size == 2'd0)      ew = {4{wdata[7:0]}};
      else if (size == 2'd1) ew = {2{wdata[15:0]}};
      else                   ew = wdata;
      mis  = (size == 2'd1 && addr[0]) || (size == 2'd2 && addr[1:0] != 2'd0);
      fl   = (fc >= 0) && (fc <= aw + dw + 2);
      last = aw + dw + 3;
      ev   = !we && !errr && !fl;
      s_req_i = 1'b1; s_we_i = we; s_addr_i = addr; s_wdata_i = wdata;
      s_size_i = size; s_unsigned_i = uns; s_flush_i = (fc == 0);
      s_hready_i = 1'b0; s_hresp_i = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      if (mis) begin
         @(negedge s_clk_i);
         s_req_i = 1'b0; s_flush_i = 1'b0;
         check("mis_stall", 32'(s_stall_o), 32'd1);
         check("mis_htrans", 32'(s_htrans_o), 32'd0);
         check("mis_done", 32'(s_done_o), 32'(fc != 0));
         check("mis_err", 32'(s_err_o), 32'(fc != 0));
         check("mis_val", 32'(s_ldata_val_o), 32'd0);
         check("mis_info", 32'(s_ld_info_o), 32'(ei));
         return;
      end
`else
      if (mis) ea = ea;
`endif
      for (int k = 1; k <= last; k++) begin
         @(negedge s_clk_i);
         s_req_i = 1'b0;
         if (k <= aw + 1) begin
            check("addr_htrans", 32'(s_htrans_o), 32'd2);
            check("addr_haddr", s_haddr_o, ea);
            check("addr_hsize", 32'(s_hsize_o), 32'(size));
            check("addr_hwrite", 32'(s_hwrite_o), 32'(we));
            check("addr_stall", 32'(s_stall_o), 32'd1);
         end else if (k < last) begin
            check("data_htrans", 32'(s_htrans_o), 32'd0);
            check("data_stall", 32'(s_stall_o), 32'd1);
            if (we) check("data_hwdata", s_hwdata_o, ew);
         end
         if (k < last) begin
            check("early_done", 32'(s_done_o), 32'd0);
            check("early_val", 32'(s_ldata_val_o), 32'd0);
            check("early_err", 32'(s_err_o), 32'd0);
         end else begin
            check("done", 32'(s_done_o), 32'(!fl));
            check("err", 32'(s_err_o), 32'(errr && !fl));
            check("ldata_val", 32'(s_ldata_val_o), 32'(ev));
            check("end_stall", 32'(s_stall_o), 32'd0);
            check("ld_info", 32'(s_ld_info_o), 32'(ei));
            if (ev) check("ldata", s_ldata_o, rdata);
            else if (ldata_known) check("ldata_hold", s_ldata_o, last_ldata);
            if (ev) begin
               last_ldata  = rdata;
               ldata_known = 1'b1;
            end else if (!we && fl) begin
               ldata_known = 1'b0;
            end
         end
         s_hready_i = (k == aw + 1) || (k == aw + dw + 2);
         s_hresp_i  = errr && (k >= aw + dw + 1) && (k <= aw + dw + 2);
         s_hrdata_i = (k == aw + dw + 2) ? rdata : $urandom;
         s_flush_i  = (k == fc);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #12;
      check("rst_stall", 32'(s_stall_o), 32'd0);
      check("rst_htrans", 32'(s_htrans_o), 32'd0);
      check("rst_done", 32'(s_done_o), 32'd0);
      check("rst_info", 32'(s_ld_info_o), 32'd0);
      check("rst_ldata", s_ldata_o, 32'd0);
      check("rst_haddr", s_haddr_o, 32'd0);
      @(negedge s_clk_i);
      s_reset_i = 1'b0;
      @(negedge s_clk_i);

      run_txn(1'b0, 32'h1000, 32'd0, 2'd2, 1'b0, 0, 0, 1'b0, -1, 32'hDEADBEEF);
      run_txn(1'b0, 32'h2003, 32'd0, 2'd0, 1'b1, 0, 2, 1'b0, -1, 32'h11223344);
      run_txn(1'b1, 32'h3002, 32'h0000ABCD, 2'd1, 1'b0, 0, 0, 1'b0, -1, 32'd0);
      run_txn(1'b0, 32'h4000, 32'd0, 2'd2, 1'b0, 1, 1, 1'b1, -1, 32'hBAD0BAD0);
      run_txn(1'b0, 32'h5000, 32'd0, 2'd2, 1'b0, 0, 1, 1'b0, 2, 32'hCAFEF00D);
      run_txn(1'b0, 32'h6000, 32'd0, 2'd2, 1'b0, 1, 0, 1'b0, 0, 32'h01010101);
      run_txn(1'b0, 32'h1002, 32'd0, 2'd2, 1'b0, 0, 0, 1'b0, -1, 32'h5A5AA5A5);

      // Reset while the address phase is on the bus.
      @(negedge s_clk_i);
      s_req_i = 1'b1; s_we_i = 1'b0; s_addr_i = 32'h7000; s_size_i = 2'd2; s_hready_i = 1'b0;
      @(negedge s_clk_i);
      s_req_i = 1'b0;
      check("pre_rst_htrans", 32'(s_htrans_o), 32'd2);
      #2 s_reset_i = 1'b1;
      #1;
      check("mid_rst_htrans", 32'(s_htrans_o), 32'd0);
      check("mid_rst_stall", 32'(s_stall_o), 32'd0);
      @(negedge s_clk_i);
      s_reset_i = 1'b0;
      s_hready_i = 1'b1;
      last_ldata = 32'd0; ldata_known = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge s_clk_i);
         check("post_rst_done", 32'(s_done_o), 32'd0);
         check("post_rst_stall", 32'(s_stall_o), 32'd0);
      end

      for (int t = 0; t < 60; t++) begin
         logic       rwe, rerr;
         logic [1:0] rsz;
         int         raw, rdw, rfc;
         rwe  = 1'($urandom_range(0, 1));
         rsz  = 2'($urandom_range(0, 2));
         raw  = $urandom_range(0, 2);
         rdw  = $urandom_range(0, 2);
         rerr = ($urandom_range(0, 5) == 0);
         if (rerr && rdw == 0) rdw = 1;
         rfc  = ($urandom_range(0, 4) == 0) ? $urandom_range(0, raw + rdw + 2) : -1;
         run_txn(rwe, $urandom, $urandom, rsz, 1'($urandom_range(0, 1)), raw, rdw, rerr, rfc, $urandom);
      end

      @(negedge s_clk_i);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
